// File: rtl/cpu_stack_ctl.sv
// rtl/cpu_stack_ctl.sv - operand stack controller: on-chip top-of-stack buffer with spill/fill to backing memory
module cpu_stack_ctl #(
  parameter int          DEPTH   = 8,
  parameter int          W       = 35,
  parameter logic [31:0] SP_BASE = 32'h0000_1000
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         op_valid,
  input  logic [1:0]   op_pop,
  input  logic         op_push,
  input  logic [W-1:0] op_data,
  output logic         stall,
  output logic [W-1:0] tos0,
  output logic [W-1:0] tos1,
  output logic [3:0]   count,
  output logic         underflow,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] stk_q [DEPTH];
  logic [W-1:0] stk_n [DEPTH];
  logic [3:0]   count_q, count_n, kept;
  logic [31:0]  sp_q, mcnt;
  logic         need_fill, need_spill, accept, pop_short;
  int           src;

  assign mcnt       = sp_q - SP_BASE;
  assign pop_short  = {2'b00, op_pop} > count_q;
  assign need_fill  = pop_short && (mcnt != 32'd0);
  assign need_spill = (int'(count_q) - int'(op_pop) + int'(op_push)) > DEPTH;
  assign stall      = op_valid & ((state_q != IDLE) | need_fill | need_spill);
  assign accept     = op_valid & ~stall;

  assign count = count_q;
  assign tos0  = (count_q > 4'd0) ? stk_q[0] : '0;
  assign tos1  = (count_q > 4'd1) ? stk_q[1] : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (op_valid && need_spill)     state_d = SPILL;
        else if (op_valid && need_fill) state_d = FILL;
      end
      SPILL, FILL: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is the top; pops shift entries up, a push shifts down and lands at 0.
  always_comb begin
    src     = 0;
    kept    = pop_short ? 4'd0 : count_q - {2'b00, op_pop};
    count_n = kept + {3'b000, op_push};
    for (int i = 0; i < DEPTH; i++) begin
      src = op_push ? (i - 1 + int'(op_pop)) : (i + int'(op_pop));
      if (op_push && i == 0)        stk_n[i] = op_data;
      else if (src >= 0 && src < DEPTH) stk_n[i] = stk_q[AW'(src)];
      else                          stk_n[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q   <= 4'd0;
      sp_q      <= SP_BASE;
      underflow <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && need_spill) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= sp_q;
            mem_wdata <= stk_q[AW'(count_q - 4'd1)];
          end else if (op_valid && need_fill) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= sp_q - 32'd1;
          end else if (accept) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_n[i];
            count_q <= count_n;
            if (pop_short) underflow <= 1'b1;
          end
        end
        SPILL: if (mem_ack) begin
          mem_req <= 1'b0;
          sp_q    <= sp_q + 32'd1;
          count_q <= count_q - 4'd1;
        end
        FILL: if (mem_ack) begin
          mem_req                 <= 1'b0;
          stk_q[AW'(count_q)]     <= mem_rdata;
          sp_q                    <= sp_q - 32'd1;
          count_q                 <= count_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
